comb_decimator: RTL
===================

COMB_DECIMATOR -- requirements
Module: comb_decimator

Interface
REQ-001 Parameter n, default 16: input sample width, signed two's complement.
REQ-002 Parameter m, default 17: output width; m >= n.
REQ-003 Parameter r, default 4: decimation ratio; r >= 1.
REQ-004 Parameter d, default 1: differential delay in decimated samples; d in {1, 2}.
REQ-005 clk  input  1  single clock; every register updates on the clk posedge only.
REQ-006 clr  input  1  reset, synchronous and active-high.
REQ-007 in  input  n  signed sample, typically an integrator output.
REQ-008 in_valid  input  1  in is accepted on a posedge where in_valid=1.
REQ-009 out  output  m  signed difference, registered.
REQ-010 out_valid  output  1  one-cycle strobe; out is new on the cycle out_valid=1.

Function
REQ-011 A phase counter (0..r-1) SHALL advance only on accepted samples and wrap from r-1 to 0.
REQ-012 An accepted sample with phase counter = 0 SHALL be a kept sample.
- Kept sample indices after clr are 0, r, 2r, ...
- Accepted samples at other phases SHALL be discarded.
REQ-013 A d-entry history of m-bit sign-extended kept samples SHALL hold the previous d kept samples; entries are 0 after clr.
REQ-014 On a kept sample x, out SHALL become sext(x) - hist[d-1] at the next posedge.
- Latency: 1 clk.
- The history SHALL shift in sext(x) at the same posedge.
REQ-015 Subtraction SHALL be computed in m bits with modular two's-complement wrap-around and no saturation, so that integrator wrap cancels.
REQ-016 out_valid SHALL be 1 for exactly the cycle after each kept sample and 0 otherwise.
REQ-017 out SHALL hold its last value between strobes.
REQ-018 With r=1, every accepted sample SHALL be kept; out_valid SHALL follow in_valid delayed by 1 clk.
REQ-019 in_valid=0 SHALL freeze the counter, history and out; out_valid SHALL be 0 on the next cycle.
REQ-020 in SHALL be ignored when in_valid=0.

Reset
REQ-021 clr=1 at a posedge SHALL set out=0, out_valid=0, phase counter=0 and all history entries to 0.
REQ-022 clr SHALL take priority over a simultaneous in_valid=1; that sample SHALL be discarded.
REQ-023 The first accepted sample after clr deasserts SHALL be a kept sample (phase 0).
REQ-024 A clr asserted in the middle of a decimation period SHALL abandon the partial period; no out_valid SHALL result from it.

Structure
REQ-025 No shared package SHALL be required; n, m, r and d are module parameters.
- Phase counter width SHALL be derived as clog2(r), minimum 1 bit.
REQ-026 The d-deep history register SHALL be a sub-module, sample_delay.
- Parameters: width m, depth d.
- Ports: clk, clr, en, din, dout.

Verification
REQ-027 r=1, d=1, in_valid=1, in=5,5,5 -> out 5,0,0; out_valid=1 on each of the 3 following cycles.
REQ-028 r=4, d=1, in_valid=1, in=0..11 ramp -> kept samples 0,4,8 -> out 0,4,4.
- out_valid SHALL pulse on cycles 1, 5 and 9 after the first sample.
REQ-029 r=1, d=2, in=1,2,4,8 -> out 1,2,3,6.
REQ-030 n=16, m=16, r=1, d=1, in=0x7FFF then 0x8000 -> out 0x7FFF then 0x0001 (wrap).
REQ-031 r=1, in=10,20, then clr=1 with in_valid=1, in=30, then in=40.
- After the clr cycle: out=0, out_valid=0.
- Then out=40.
REQ-032 r=2, d=1, in_valid pattern 1,0,1,1,0,1 with in=3,x,7,9,x,15 -> kept 3,9 -> out 3,6.
- out_valid SHALL be high only in the cycles after the 3 and the 9 are accepted.

Source files
------------

// File: rtl/sample_delay.sv
// Delay line of `depth` words that advances only when `en` is high.
// `dout` is the oldest entry, i.e. the word written `depth` enables ago.
module sample_delay #(
  parameter int width = 17,
  parameter int depth = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);

  logic [width-1:0] hist_q [depth];

  always_ff @(posedge clk) begin
    // NOTE: the history is only a few words of flops and must clear, so that the first difference after clr subtracts zero.
    if (clr) begin
      for (int i = 0; i < depth; i++) hist_q[i] <= '0;
    end else if (en) begin
      hist_q[0] <= din;
      for (int i = 1; i < depth; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  assign dout = hist_q[depth-1];

endmodule

// File: rtl/comb_decimator.sv
// CIC comb stage: keeps every r-th accepted sample and outputs its modular
// difference from the kept sample d positions earlier.
module comb_decimator #(
  parameter int n = 16,
  parameter int m = 17,
  parameter int r = 4,
  parameter int d = 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic signed [n-1:0] in,
  input  logic                in_valid,
  output logic signed [m-1:0] out,
  output logic                out_valid
);

  localparam int cw = (r > 1) ? $clog2(r) : 1;
  localparam logic [cw-1:0] phase_last = cw'(r - 1);

  logic [cw-1:0]       phase_q, phase_d;
  logic signed [m-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                keep;
  logic signed [m-1:0] in_ext;
  logic signed [m-1:0] hist_tail;

  assign in_ext = m'(in);
  assign keep   = in_valid && (phase_q == '0);

  sample_delay #(
    .width(m),
    .depth(d)
  ) u_hist (
    .clk (clk),
    .clr (clr),
    .en  (keep),
    .din (in_ext),
    .dout(hist_tail)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    phase_d     = phase_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      phase_d = (phase_q == phase_last) ? '0 : phase_q + cw'(1);
    end
    if (keep) begin
      // Plain m-bit subtraction: integrator wrap-around cancels here.
      out_d       = in_ext - hist_tail;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (clr) begin
      phase_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
